pipe_stage_skid: RTL and testbench

Parametrised pipeline-stage register, the successor to the fixed-width IF/ID latch with plain stall. It carries a `DATA_W`-bit payload (instruction, PC+4, PC+8 or any other stage bundle) between two pipeline stages. It uses a valid/ready handshake, a one-entry skid buffer so that `in_ready` is a pure register output, and a synchronous flush that inserts a bubble. It sits between every adjacent pair of stages (F/D, D/E, E/M, M/W) and adds a saturating back-pressure counter for performance analysis.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/pipe_stage_skid_sat_counter.sv | 26 ++
 rtl/pipe_stage_skid.sv | 103 ++++++++++
 tb/tb_pipe_stage_skid.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline-stage register family.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_t;

  // NOP encoding of a single 32-bit instruction field.
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  localparam int unsigned DEFAULT_DATA_W = 96;
  localparam int unsigned DEFAULT_CNT_W  = 16;

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter with asynchronous active-high reset.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;
  logic             w_at_max;

  assign w_at_max = &r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc && !w_at_max) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline register with a one-entry skid buffer, flush and stall counter.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W    = DEFAULT_DATA_W,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0,
  parameter int unsigned       CNT_W     = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt
);

  pipe_state_t       r_state;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic              r_out_valid;
  logic              r_in_ready;

  logic w_in_acc;
  logic w_out_acc;
  logic w_stall_inc;

  assign w_in_acc    = in_valid & r_in_ready;
  assign w_out_acc   = r_out_valid & out_ready;
  assign w_stall_inc = r_out_valid & ~out_ready;

  // Valid/ready flags are kept as their own flops so both ports see pure register outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= EMPTY;
      r_main      <= NOP_VALUE;
      r_skid      <= NOP_VALUE;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else if (flush) begin
      r_state     <= EMPTY;
      r_main      <= NOP_VALUE;
      r_skid      <= NOP_VALUE;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_acc) begin
            r_state     <= FULL;
            r_main      <= in_data;
            r_out_valid <= 1'b1;
          end
        end
        FULL: begin
          if (w_in_acc && w_out_acc) begin
            r_main <= in_data;
          end else if (w_in_acc) begin
            r_state    <= SKID;
            r_skid     <= in_data;
            r_in_ready <= 1'b0;
          end else if (w_out_acc) begin
            r_state     <= EMPTY;
            r_main      <= NOP_VALUE;
            r_out_valid <= 1'b0;
          end
        end
        SKID: begin
          if (w_out_acc) begin
            r_state    <= FULL;
            r_main     <= r_skid;
            r_skid     <= NOP_VALUE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= EMPTY;
          r_main      <= NOP_VALUE;
          r_skid      <= NOP_VALUE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign in_ready  = r_in_ready;
  assign out_data  = r_main;

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (w_stall_inc),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Randomised and directed bench for pipe_stage_skid against a queue-based model.
module tb_pipe_stage_skid;

  localparam int DW = 32;
  localparam int CW = 4;
  localparam logic [DW-1:0] NOP = 32'h0;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          flush;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  pipe_stage_skid #(
    .DATA_W   (DW),
    .NOP_VALUE(NOP),
    .CNT_W    (CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .flush    (flush),
    .stall_cnt(stall_cnt)
  );

  int errors = 0;
  int checks = 0;

  // Model: the stage is a FIFO of capacity 2 plus a saturating counter.
  logic [DW-1:0] m_q[$];
  int            m_cnt = 0;
  logic [DW-1:0] consumed[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    check("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
    check("in_ready", 32'(in_ready), 32'(m_q.size() < 2));
    check("out_data", out_data, (m_q.size() > 0) ? m_q[0] : NOP);
    check("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
  endtask

  // One clock edge: record consumption, advance the model, then compare.
  task automatic step();
    bit mv, mr;
    mv = (m_q.size() > 0);
    mr = (m_q.size() < 2);
    if (out_valid && out_ready) consumed.push_back(out_data);
    @(posedge clk);
    if (mv && !out_ready && m_cnt < CNT_MAX) m_cnt++;
    if (flush) begin
      m_q.delete();
    end else begin
      if (mv && out_ready) void'(m_q.pop_front());
      if (in_valid && mr) m_q.push_back(in_data);
    end
    #1 compare();
  endtask

  // Reset pulse placed between clock edges.
  task automatic mid_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_data", out_data, NOP);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    m_q.delete();
    m_cnt = 0;
    #1 reset = 1'b0;
  endtask

  initial begin
    int hits;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    #7;
    check("init_out_valid", 32'(out_valid), 32'd0);
    check("init_in_ready", 32'(in_ready), 32'd1);
    check("init_out_data", out_data, NOP);
    check("init_stall_cnt", 32'(stall_cnt), 32'd0);
    #3 reset = 1'b0;
    repeat (2) step();

    // Streaming 1..8 at full rate.
    consumed.delete();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = 32'(i);
      step();
      check("stream_in_ready", 32'(in_ready), 32'd1);
      check("stream_latency", out_data, 32'(i));
    end
    in_valid = 1'b0;
    step();
    check("stream_count", 32'(consumed.size()), 32'd8);
    for (int i = 0; i < consumed.size(); i++) check("stream_order", consumed[i], 32'(i + 1));

    // Back-pressure into the skid entry.
    consumed.delete();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    step();
    in_data = 32'hB;
    step();
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    in_data = 32'hC;
    step();
    step();
    check("bp_stall_cnt", 32'(stall_cnt), 32'd3);
    out_ready = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    step();
    step();
    check("bp_count", 32'(consumed.size()), 32'd3);
    if (consumed.size() == 3) begin
      check("bp_order0", consumed[0], 32'hA);
      check("bp_order1", consumed[1], 32'hB);
      check("bp_order2", consumed[2], 32'hC);
    end

    // Flush while in SKID with a live input.
    consumed.delete();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h11;
    step();
    in_data = 32'h12;
    step();
    flush   = 1'b1;
    in_data = 32'hD;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_out_data", out_data, NOP);
    check("flush_stall_cnt", 32'(stall_cnt), 32'd5);
    out_ready = 1'b1;
    repeat (3) step();
    hits = 0;
    foreach (consumed[i]) if (consumed[i] == 32'hD) hits++;
    check("flush_dropped", 32'(hits), 32'd0);

    // Counter saturation.
    in_valid  = 1'b1;
    in_data   = 32'h77;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    repeat (20) step();
    check("sat_stall_cnt", 32'(stall_cnt), 32'd15);

    // Asynchronous reset while FULL, then a normal accept.
    out_ready = 1'b1;
    step();
    in_valid = 1'b1;
    in_data  = 32'h66;
    out_ready = 1'b0;
    step();
    mid_reset();
    in_data = 32'h55;
    step();
    check("post_rst_valid", 32'(out_valid), 32'd1);
    check("post_rst_data", out_data, 32'h55);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      step();
      if (i % 97 == 50) mid_reset();
    end
    flush    = 1'b0;
    in_valid = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
